// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: shared encodings and helpers for the rv32 memory stage
package rv32_mem_pkg;
    localparam logic [1:0] RV32_MEM_WIDTH_BYTE = 2'd0;
    localparam logic [1:0] RV32_MEM_WIDTH_HALF = 2'd1;
    localparam logic [1:0] RV32_MEM_WIDTH_WORD = 2'd2;
    localparam logic [1:0] RV32_BRANCH_OP_NEVER    = 2'd0;
    localparam logic [1:0] RV32_BRANCH_OP_ZERO     = 2'd1;
    localparam logic [1:0] RV32_BRANCH_OP_NON_ZERO = 2'd2;
    localparam logic [1:0] RV32_BRANCH_OP_ALWAYS   = 2'd3;
    typedef enum logic {IDLE, BUSY} state_t;
    // Anything wider than a half, including the reserved encoding, is a word.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr);
        return (width == RV32_MEM_WIDTH_HALF) ? addr[0] :
               (width != RV32_MEM_WIDTH_BYTE) && (addr != 2'b00);
    endfunction
endpackage

// File: rtl/rv32_load_align.sv
// rv32_load_align: selects the addressed byte/half of a read word and extends it to 32 bits
module rv32_load_align
    import rv32_mem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  width,
    input  logic        zero_extend,
    input  logic [31:0] raw,
    output logic [31:0] value
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = addr[1] ? (addr[0] ? raw[31:24] : raw[23:16]) : (addr[0] ? raw[15:8] : raw[7:0]);
    assign h = addr[1] ? raw[31:16] : raw[15:0];
    assign value = (width == RV32_MEM_WIDTH_BYTE) ? {{24{~zero_extend & b[7]}}, b} :
                   (width == RV32_MEM_WIDTH_HALF) ? {{16{~zero_extend & h[15]}}, h} : raw;
endmodule

// File: rtl/rv32_mem_access.sv
// rv32_mem_access: memory stage with single-outstanding data-bus access, branch resolve and writeback regs
module rv32_mem_access
    import rv32_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_width_in,
    input  logic        mem_zero_extend_in,
    input  logic [1:0]  branch_op_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_write_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rs2_value_in,
    input  logic [31:0] branch_pc_in,
    output logic [31:0] dbus_address_out,
    output logic        dbus_read_out,
    output logic        dbus_write_out,
    output logic [3:0]  dbus_write_mask_out,
    output logic [31:0] dbus_write_value_out,
    input  logic [31:0] dbus_read_value_in,
    input  logic        dbus_ready_in,
    output logic        stall_out,
    output logic        misaligned_out,
    output logic        branch_taken_out,
    output logic [31:0] branch_pc_out,
    output logic [4:0]  rd_out,
    output logic        rd_write_out,
    output logic [31:0] rd_value_out
);
    state_t      state;
    logic        memop, mis;
    logic [3:0]  st_mask;
    logic [31:0] st_data, load_value;
    logic [1:0]  lat_addr, lat_width;
    logic        lat_zext, lat_rd_write;
    logic [4:0]  lat_rd;
    assign memop = mem_read_in | mem_write_in;
    assign mis = is_misaligned(mem_width_in, result_in[1:0]);
    assign stall_out = (state == IDLE) ? memop & ~mis : ~dbus_ready_in;
    assign branch_taken_out = (branch_op_in == RV32_BRANCH_OP_ALWAYS) ||
                              (branch_op_in == RV32_BRANCH_OP_ZERO && result_in == 32'd0) ||
                              (branch_op_in == RV32_BRANCH_OP_NON_ZERO && result_in != 32'd0);
    assign branch_pc_out = branch_pc_in;
    always_comb begin
        st_mask = (mem_width_in == RV32_MEM_WIDTH_BYTE) ? 4'b0001 << result_in[1:0] :
                  (mem_width_in == RV32_MEM_WIDTH_HALF) ? (result_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        st_data = (mem_width_in == RV32_MEM_WIDTH_BYTE) ? {4{rs2_value_in[7:0]}} :
                  (mem_width_in == RV32_MEM_WIDTH_HALF) ? {2{rs2_value_in[15:0]}} : rs2_value_in;
    end
    rv32_load_align u_align (
        .addr        (lat_addr),
        .width       (lat_width),
        .zero_extend (lat_zext),
        .raw         (dbus_read_value_in),
        .value       (load_value)
    );
    // Reads take priority so the two strobes can never be asserted together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            dbus_address_out     <= '0;
            dbus_read_out        <= 1'b0;
            dbus_write_out       <= 1'b0;
            dbus_write_mask_out  <= '0;
            dbus_write_value_out <= '0;
            misaligned_out       <= 1'b0;
            rd_out               <= '0;
            rd_write_out         <= 1'b0;
            rd_value_out         <= '0;
            lat_addr             <= '0;
            lat_width            <= '0;
            lat_zext             <= 1'b0;
            lat_rd               <= '0;
            lat_rd_write         <= 1'b0;
        end else begin
            misaligned_out <= 1'b0;
            if (state == IDLE) begin
                if (!memop) begin
                    rd_out       <= rd_in;
                    rd_write_out <= rd_write_in;
                    rd_value_out <= result_in;
                end else if (mis) begin
                    misaligned_out <= 1'b1;
                    rd_write_out   <= 1'b0;
                end else begin
                    dbus_address_out     <= {result_in[31:2], 2'b00};
                    dbus_read_out        <= mem_read_in;
                    dbus_write_out       <= ~mem_read_in;
                    dbus_write_mask_out  <= mem_read_in ? 4'b0000 : st_mask;
                    dbus_write_value_out <= st_data;
                    lat_addr             <= result_in[1:0];
                    lat_width            <= mem_width_in;
                    lat_zext             <= mem_zero_extend_in;
                    lat_rd               <= rd_in;
                    lat_rd_write         <= rd_write_in;
                    rd_write_out         <= 1'b0;
                    state                <= BUSY;
                end
            end else if (dbus_ready_in) begin
                dbus_read_out  <= 1'b0;
                dbus_write_out <= 1'b0;
                rd_write_out   <= dbus_read_out & lat_rd_write;
                if (dbus_read_out) begin
                    rd_out       <= lat_rd;
                    rd_value_out <= load_value;
                end
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_rv32_mem_access.sv
// tb_rv32_mem_access: directed vectors, corner sequences and randomized ops against a transaction-level model
module tb_rv32_mem_access;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        mem_read_in = 0, mem_write_in = 0, mem_zero_extend_in = 0, rd_write_in = 0, dbus_ready_in = 0;
    logic [1:0]  mem_width_in = 0, branch_op_in = 0;
    logic [4:0]  rd_in = 0;
    logic [31:0] result_in = 0, rs2_value_in = 0, branch_pc_in = 0, dbus_read_value_in = 0;
    logic [31:0] dbus_address_out, dbus_write_value_out, branch_pc_out, rd_value_out;
    logic        dbus_read_out, dbus_write_out, stall_out, misaligned_out, branch_taken_out, rd_write_out;
    logic [3:0]  dbus_write_mask_out;
    logic [4:0]  rd_out;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    rv32_mem_access dut (
        .clk(clk), .reset_n(reset_n),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_width_in(mem_width_in),
        .mem_zero_extend_in(mem_zero_extend_in), .branch_op_in(branch_op_in), .rd_in(rd_in),
        .rd_write_in(rd_write_in), .result_in(result_in), .rs2_value_in(rs2_value_in),
        .branch_pc_in(branch_pc_in), .dbus_address_out(dbus_address_out), .dbus_read_out(dbus_read_out),
        .dbus_write_out(dbus_write_out), .dbus_write_mask_out(dbus_write_mask_out),
        .dbus_write_value_out(dbus_write_value_out), .dbus_read_value_in(dbus_read_value_in),
        .dbus_ready_in(dbus_ready_in), .stall_out(stall_out), .misaligned_out(misaligned_out),
        .branch_taken_out(branch_taken_out), .branch_pc_out(branch_pc_out), .rd_out(rd_out),
        .rd_write_out(rd_write_out), .rd_value_out(rd_value_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] raw, input int off, input int size, input logic zx);
        logic [31:0] v, m;
        if (size == 4) return raw;
        m = (32'd1 << (size * 8)) - 32'd1;
        v = (raw >> (off * 8)) & m;
        if (!zx && v[size * 8 - 1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [3:0] ref_mask(input int off, input int size);
        logic [3:0] m = '0;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + size) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_data(input logic [31:0] rs2, input int size);
        logic [31:0] d;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = rs2[8*(i % size) +: 8];
        return d;
    endfunction

    function automatic logic ref_taken(input logic [1:0] op, input logic [31:0] res);
        return op == 2'd3 || (op == 2'd1 && res == 0) || (op == 2'd2 && res != 0);
    endfunction

    // Starts and ends at a falling edge; drives one instruction and a memory response.
    task automatic run_op(input logic ld, input logic st, input logic [1:0] width, input logic zx,
                          input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                          input int delay, input logic [4:0] rd, input logic rdw, input logic mis,
                          input logic [31:0] eaddr, input logic [3:0] emask, input logic [31:0] edata,
                          input logic ewb, input logic [31:0] evalue, input int estalls);
        int stalls;
        mem_read_in = ld; mem_write_in = st; mem_width_in = width; mem_zero_extend_in = zx;
        result_in = addr; rs2_value_in = rs2; rd_in = rd; rd_write_in = rdw; dbus_ready_in = 0;
        #1;
        chk("branch_taken", branch_taken_out, ref_taken(branch_op_in, addr));
        chk("branch_pc", branch_pc_out, branch_pc_in);
        if (!ld && !st) begin
            chk("stall_alu", stall_out, 0);
            @(negedge clk);
            chk("wb_rd", rd_out, rd);
            chk("wb_write", rd_write_out, ewb);
            chk("wb_value", rd_value_out, evalue);
            chk("alu_strobe", {dbus_read_out, dbus_write_out}, 0);
            chk("alu_mis", misaligned_out, 0);
        end else if (mis) begin
            chk("stall_mis", stall_out, 0);
            @(negedge clk);
            chk("mis_pulse", misaligned_out, 1);
            chk("mis_strobe", {dbus_read_out, dbus_write_out}, 0);
            chk("mis_wb_write", rd_write_out, 0);
        end else begin
            stalls = int'(stall_out);
            @(negedge clk);
            chk("req_addr", dbus_address_out, eaddr);
            chk("req_read", dbus_read_out, ld);
            chk("req_write", dbus_write_out, st);
            chk("req_bubble", rd_write_out, 0);
            chk("req_mis", misaligned_out, 0);
            if (st) begin
                chk("req_mask", dbus_write_mask_out, emask);
                chk("req_data", dbus_write_value_out, edata);
            end
            for (int i = 0; i < delay; i++) begin
                stalls += int'(stall_out);
                @(negedge clk);
                chk("hold_addr", dbus_address_out, eaddr);
                chk("hold_strobe", {dbus_read_out, dbus_write_out}, {ld, st});
            end
            dbus_ready_in = 1; dbus_read_value_in = rdata;
            #1;
            chk("stall_ready", stall_out, 0);
            @(negedge clk);
            dbus_ready_in = 0;
            chk("done_strobe", {dbus_read_out, dbus_write_out}, 0);
            chk("done_wb_write", rd_write_out, ewb);
            chk("stall_cycles", stalls, estalls);
            if (ld) begin
                chk("load_value", rd_value_out, evalue);
                chk("load_rd", rd_out, rd);
            end
        end
        mem_read_in = 0; mem_write_in = 0;
    endtask

    typedef struct {
        logic ld, st; logic [1:0] width; logic zx; logic [31:0] addr, rs2, rdata; int delay;
        logic [4:0] rd; logic rdw; logic mis; logic [31:0] eaddr; logic [3:0] emask;
        logic [31:0] edata; logic ewb; logic [31:0] evalue; int estalls;
    } vec_t;
    vec_t vecs[12];

    initial begin
        logic [7:0] bexp;
        vecs[0]  = '{1, 0, 2, 0, 32'h100, 0, 32'hDEADBEEF, 3, 5, 1, 0, 32'h100, 0, 0, 1, 32'hDEADBEEF, 4};
        vecs[1]  = '{0, 1, 0, 0, 32'h203, 32'h12345678, 0, 1, 9, 1, 0, 32'h200, 4'b1000, 32'h78787878, 0, 0, 2};
        vecs[2]  = '{1, 0, 1, 0, 32'h2, 0, 32'h80010000, 0, 6, 1, 0, 32'h0, 0, 0, 1, 32'hFFFF8001, 1};
        vecs[3]  = '{1, 0, 1, 1, 32'h2, 0, 32'h80010000, 0, 6, 1, 0, 32'h0, 0, 0, 1, 32'h00008001, 1};
        vecs[4]  = '{1, 0, 2, 0, 32'h101, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 32'hCAFE0001, 0, 0, 0, 7, 1, 0, 0, 0, 0, 1, 32'hCAFE0001, 0};
        vecs[6]  = '{0, 1, 1, 0, 32'h6, 32'hAABBCCDD, 0, 2, 1, 0, 0, 32'h4, 4'b1100, 32'hCCDDCCDD, 0, 0, 3};
        vecs[7]  = '{0, 1, 1, 0, 32'h3, 32'h1, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{1, 0, 0, 0, 32'h1, 0, 32'h00008000, 0, 8, 1, 0, 32'h0, 0, 0, 1, 32'hFFFFFF80, 1};
        vecs[9]  = '{0, 1, 2, 0, 32'h10, 32'h01020304, 0, 1, 3, 1, 0, 32'h10, 4'b1111, 32'h01020304, 0, 0, 2};
        vecs[10] = '{1, 0, 3, 0, 32'h20, 0, 32'h11223344, 0, 2, 0, 0, 32'h20, 0, 0, 0, 32'h11223344, 1};
        vecs[11] = '{0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0};

        repeat (2) @(negedge clk);
        chk("rst_addr", dbus_address_out, 0);
        chk("rst_strobe", {dbus_read_out, dbus_write_out}, 0);
        chk("rst_mask", dbus_write_mask_out, 0);
        chk("rst_wdata", dbus_write_value_out, 0);
        chk("rst_rd", rd_out, 0);
        chk("rst_rd_write", rd_write_out, 0);
        chk("rst_rd_value", rd_value_out, 0);
        chk("rst_mis", misaligned_out, 0);
        chk("rst_stall", stall_out, 0);
        reset_n = 1;

        for (int i = 0; i < 12; i++) begin
            branch_op_in = 2'($urandom); branch_pc_in = $urandom;
            run_op(vecs[i].ld, vecs[i].st, vecs[i].width, vecs[i].zx, vecs[i].addr, vecs[i].rs2,
                   vecs[i].rdata, vecs[i].delay, vecs[i].rd, vecs[i].rdw, vecs[i].mis, vecs[i].eaddr,
                   vecs[i].emask, vecs[i].edata, vecs[i].ewb, vecs[i].evalue, vecs[i].estalls);
        end

        bexp = 8'b11100100;
        for (int op = 0; op < 4; op++) begin
            for (int r = 0; r < 2; r++) begin
                branch_op_in = 2'(op); result_in = 32'(r); branch_pc_in = $urandom;
                #1;
                chk("branch_table", branch_taken_out, bexp[op*2 + r]);
                chk("branch_table_pc", branch_pc_out, branch_pc_in);
            end
        end
        @(negedge clk);

        // Reset while a load is outstanding, then a late ready must be ignored.
        mem_read_in = 1; mem_width_in = 2; result_in = 32'h40; rd_in = 3; rd_write_in = 1; dbus_ready_in = 0;
        @(negedge clk);
        chk("rst_busy_read", dbus_read_out, 1);
        reset_n = 0;
        #1;
        chk("rst_read_drop", dbus_read_out, 0);
        chk("rst_busy_wb", rd_write_out, 0);
        mem_read_in = 0; rd_write_in = 0; dbus_ready_in = 1;
        @(negedge clk);
        reset_n = 1;
        #1;
        chk("rst_stall_after", stall_out, 0);
        @(negedge clk);
        chk("rst_late_ready_read", dbus_read_out, 0);
        chk("rst_late_ready_wb", rd_write_out, 0);
        dbus_ready_in = 0;

        for (int n = 0; n < 300; n++) begin
            int kind, size, delay;
            logic [1:0] width; logic zx, rdw, mis; logic [31:0] addr, rs2, rdata; logic [4:0] rd;
            kind = $urandom_range(0, 2); width = 2'($urandom); zx = 1'($urandom);
            addr = $urandom; rs2 = $urandom; rdata = $urandom; delay = $urandom_range(0, 3);
            rd = 5'($urandom); rdw = 1'($urandom);
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) addr = 0;
            branch_op_in = 2'($urandom); branch_pc_in = $urandom;
            size = (width == 0) ? 1 : (width == 1) ? 2 : 4;
            mis = kind != 0 && (addr % size) != 0;
            run_op(kind == 1, kind == 2, width, zx, addr, rs2, rdata, delay, rd, rdw, mis,
                   addr & ~32'd3, ref_mask(int'(addr % 4), size), ref_data(rs2, size),
                   (kind != 2 && !mis) ? rdw : 1'b0,
                   (kind == 0) ? addr : ref_load(rdata, int'(addr % 4), size, zx), 1 + delay);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
